mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Control and sequencing block for the multiply/divide unit in the EX stage.
- Accepts one M-extension op per request.
- Steps a multi-cycle multiplier pipeline and a radix-2 restoring divider.
- Drives mul_stall_o / div_stall_o so the EX/MEM register holds until the result is valid.
- Handles RISC-V divide special cases and squashed requests.

Parameters:
XLEN, 32, operand/result width
MUL_LATENCY, 2, multiplier busy cycles after acceptance (legal range 1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  MDU request valid; held high with stable operands while stalled
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  in  XLEN  forwarded operand 1
rs2_i  in  XLEN  forwarded operand 2
freeze_i  in  1  pipeline busywait; the pipeline register will not capture this cycle
result_o  out  XLEN  registered result, valid when done_o=1
done_o  out  1  result valid (state DONE)
mul_stall_o  out  1  stall request for a multiply op
div_stall_o  out  1  stall request for a divide/remainder op
busy_o  out  1  state is MUL_BUSY or DIV_BUSY

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset: state=IDLE; result_o=0; done_o=0; busy_o=0; counters and operand registers=0. Stall outputs evaluate to 0 while en_i=0.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE, en_i=1, op_i[2]=0:
  - Latch operands. Sign-extend to 33 bits per op (MULHSU: rs1 signed, rs2 unsigned).
  - Go to MUL_BUSY with cnt=MUL_LATENCY-1.
- MUL_BUSY: decrement cnt; at cnt=0 go to DONE and load result_o.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- IDLE, en_i=1, op_i[2]=1, normal case:
  - Latch |rs1| and |rs2| for signed ops, plus the quotient and remainder signs.
  - Go to DIV_BUSY with cnt=31.
  - Each cycle performs one restoring step (shift remainder, trial subtract, set quotient bit).
  - At cnt=0 go to DONE. Apply sign fix: quotient negated if the operand signs differ; remainder takes the sign of rs1.
- Divide fast path (IDLE → DONE directly, one stall cycle):
  - rs2=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Stall outputs (combinational):
  - mul_stall_o = en_i & !op_i[2] & (state==IDLE | state==MUL_BUSY).
  - div_stall_o = en_i & op_i[2] & (state==IDLE | state==DIV_BUSY).
  - Both are 0 in DONE, so the pipeline captures result_o on that edge.
- Stall timing:
  - Multiply stall lasts 1+MUL_LATENCY cycles (3 at default).
  - Normal divide stall lasts 33 cycles; fast-path divide stall lasts 1 cycle.
- DONE: done_o=1. If freeze_i=1, stay in DONE holding result_o. If freeze_i=0, go to IDLE next edge. DONE never accepts a new op.
- Squash: en_i=0 during MUL_BUSY or DIV_BUSY aborts to IDLE next edge. result_o is unchanged and done_o is not asserted.
- freeze_i does not pause MUL_BUSY or DIV_BUSY; computation continues.
- Reset mid-operation: immediate IDLE, all outputs cleared, no residual result.
- Back-to-back ops: a new op is accepted only in IDLE, one cycle after DONE. The stall covers that cycle because en_i and the op are already presented in IDLE.

Optional Feature:
Macro: MDU_DIV_REUSE_EN.
- Defined:
  - Keep the last completed divide's rs1, rs2, signedness, quotient and remainder in a one-entry cache.
  - A DIV/REM request in IDLE whose rs1, rs2 and op_i[0] all match the cache goes to DONE with a 1-cycle stall. It returns the cached quotient or remainder as selected by op_i[1].
  - The cache is invalidated on reset and on squash.
- Not defined: no cache; every normal divide takes 33 stall cycles.

Decomposition:
- Package mdu_pkg holds:
  - funct3 constants (MUL_FUNCT3 … REMU_FUNCT3).
  - State encoding (2-bit localparams).
  - XLEN.
  - Divide special constants: all-ones and INT_MIN.
- Natural sub-module: mdu_div_step. It is the combinational one-bit restoring step (remainder/quotient in, remainder/quotient out). The sequencer owns all registers and the FSM.

Test Plan:
- MUL: rs1=7, rs2=6 → mul_stall_o high 3 cycles; DONE result_o=42, done_o=1 for 1 cycle.
- MULH/MULHU: rs1=rs2=0xFFFFFFFF → MULH result 0x00000000; MULHU result 0xFFFFFFFE.
- DIV/REM normal: rs1=-7 (0xFFFFFFF9), rs2=2 → div_stall_o high 33 cycles; DIV result 0xFFFFFFFD (-3); REM result 0xFFFFFFFF (-1).
- Divide special cases, 1-cycle stall each: DIVU x/0 with rs1=5 → 0xFFFFFFFF; REMU x/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Squash and reset: drop en_i at DIV_BUSY cycle 10 → IDLE next cycle, done_o never asserts. Assert rst_i asynchronously mid-MUL → outputs 0 at once, and a fresh MUL 3×3 returns 9.
- freeze_i in DONE: hold freeze_i 4 cycles → result_o stable, done_o high 4 cycles, then IDLE. With MDU_DIV_REUSE_EN, DIV then REM on the same operands → the REM stall is 1 cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants for the multiply/divide sequencer
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] MUL_FUNCT3    = 3'b000;
    localparam logic [2:0] MULH_FUNCT3   = 3'b001;
    localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
    localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
    localparam logic [2:0] DIV_FUNCT3    = 3'b100;
    localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
    localparam logic [2:0] REM_FUNCT3    = 3'b110;
    localparam logic [2:0] REMU_FUNCT3   = 3'b111;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] ST_DIV_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] DIV_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem_i < dvs_i, so a non-negative diff never sets bit W; bit W is the borrow
    assign shifted = {rem_i, quo_i[W-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    assign quo_o   = {quo_i[W-2:0], ~diff[W]};

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - M-extension sequencer; MDU_DIV_REUSE_EN enables a one-entry divide result cache
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            freeze_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            mul_stall_o,
    output logic            div_stall_o,
    output logic            busy_o
);

    localparam int PW = 2 * XLEN;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic signed [XLEN:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [XLEN-1:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic                   q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic                   div_signed, rs1_neg, rs2_neg;
    logic                   div_by_zero, div_overflow, div_fast, cache_hit;
    logic [XLEN-1:0]        rs1_abs, rs2_abs, fast_result, cache_result;
    logic [XLEN-1:0]        step_rem, step_quo, quo_fix, rem_fix, div_result, mul_result;
    logic [PW-1:0]          prod;

    assign div_signed   = ~op_i[0];
    assign rs1_neg      = div_signed & rs1_i[XLEN-1];
    assign rs2_neg      = div_signed & rs2_i[XLEN-1];
    assign rs1_abs      = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_abs      = rs2_neg ? -rs2_i : rs2_i;
    assign div_by_zero  = (rs2_i == '0);
    assign div_overflow = div_signed && (rs1_i == DIV_INT_MIN) && (rs2_i == DIV_ALL_ONES);
    assign div_fast     = div_by_zero | div_overflow;

    always_comb begin
        fast_result = op_i[1] ? '0 : DIV_INT_MIN;
        if (div_by_zero) begin
            fast_result = op_i[1] ? rs1_i : DIV_ALL_ONES;
        end
    end

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign quo_fix    = q_neg_q ? -step_quo : step_quo;
    assign rem_fix    = r_neg_q ? -step_rem : step_rem;
    assign div_result = op_q[1] ? rem_fix : quo_fix;

    // 33-bit operands sign-extended to 64 bits; the low 64 bits of the product are exact
    assign prod       = {{(XLEN-1){mul_a_q[XLEN]}}, mul_a_q} * {{(XLEN-1){mul_b_q[XLEN]}}, mul_b_q};
    assign mul_result = (op_q == MUL_FUNCT3) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

`ifdef MDU_DIV_REUSE_EN
    logic            c_valid_q, c_valid_d, c_uns_q, c_uns_d;
    logic [XLEN-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;

    assign cache_hit    = c_valid_q && (rs1_i == c_rs1_q) && (rs2_i == c_rs2_q) && (op_i[0] == c_uns_q);
    assign cache_result = op_i[1] ? c_rem_q : c_quo_q;

    always_comb begin
        c_valid_d = c_valid_q;
        c_uns_d   = c_uns_q;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_quo_d   = c_quo_q;
        c_rem_d   = c_rem_q;
        if (state_q == ST_IDLE && en_i && op_i[2] && !div_fast && !cache_hit) begin
            c_valid_d = 1'b0;
            c_uns_d   = op_i[0];
            c_rs1_d   = rs1_i;
            c_rs2_d   = rs2_i;
        end
        if (state_q == ST_DIV_BUSY) begin
            if (!en_i) begin
                c_valid_d = 1'b0;
            end else if (cnt_q == '0) begin
                c_valid_d = 1'b1;
                c_quo_d   = quo_fix;
                c_rem_d   = rem_fix;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_valid_q <= 1'b0;
            c_uns_q   <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
        end else begin
            c_valid_q <= c_valid_d;
            c_uns_q   <= c_uns_d;
            c_rs1_q   <= c_rs1_d;
            c_rs2_q   <= c_rs2_d;
            c_quo_q   <= c_quo_d;
            c_rem_q   <= c_rem_d;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    if (!op_i[2])                   state_d = ST_MUL_BUSY;
                    else if (div_fast || cache_hit) state_d = ST_DONE;
                    else                            state_d = ST_DIV_BUSY;
                end
            end
            ST_MUL_BUSY, ST_DIV_BUSY: begin
                if (!en_i)              state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_DONE;
            end
            default: begin
                if (!freeze_i) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    op_d = op_i;
                    if (!op_i[2]) begin
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                        mul_a_d = {(op_i[1:0] != 2'b11) & rs1_i[XLEN-1], rs1_i};
                        mul_b_d = {~op_i[1] & rs2_i[XLEN-1], rs2_i};
                    end else if (div_fast) begin
                        result_d = fast_result;
                    end else if (cache_hit) begin
                        result_d = cache_result;
                    end else begin
                        cnt_d   = CNT_W'(XLEN - 1);
                        rem_d   = '0;
                        quo_d   = rs1_abs;
                        dvs_d   = rs2_abs;
                        q_neg_d = rs1_neg ^ rs2_neg;
                        r_neg_d = rs1_neg;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (en_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) result_d = mul_result;
                end
            end
            ST_DIV_BUSY: begin
                if (en_i) begin
                    cnt_d = cnt_q - 1'b1;
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) result_d = div_result;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            op_q     <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // Stalls drop in DONE so the EX/MEM register captures result_o on that edge
    always_comb begin
        mul_stall_o = en_i & ~op_i[2] & ((state_q == ST_IDLE) | (state_q == ST_MUL_BUSY));
        div_stall_o = en_i &  op_i[2] & ((state_q == ST_IDLE) | (state_q == ST_DIV_BUSY));
        done_o      = (state_q == ST_DONE);
        busy_o      = (state_q == ST_MUL_BUSY) | (state_q == ST_DIV_BUSY);
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

    localparam int MUL_LAT = 2;

    logic        clk_i, rst_i, en_i, freeze_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i, result_o;
    logic        done_o, mul_stall_o, div_stall_o, busy_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] last_result = 32'h0;
    bit          c_v = 1'b0;
    bit          c_u = 1'b0;
    logic [31:0] c_a = 32'h0;
    logic [31:0] c_b = 32'h0;

    mdu_sequencer #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .freeze_i    (freeze_i),
        .result_o    (result_o),
        .done_o      (done_o),
        .mul_stall_o (mul_stall_o),
        .div_stall_o (div_stall_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        logic [63:0]     p;
        case (op)
            3'd0: begin p = ua * ub;             return p[31:0];  end
            3'd1: begin p = sa * sb;             return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);   return p[63:32]; end
            3'd3: begin p = ua * ub;             return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_stall(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1 + MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MDU_DIV_REUSE_EN
        if (c_v && a == c_a && b == c_b && op[0] == c_u) return 1;
`endif
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit keep, input int freeze_n);
        logic [31:0] exp_r;
        int          exp_s;
        int          st_want = 0;
        int          st_other = 0;
        bit          seen = 1'b0;
        string       t;
        exp_r = ref_result(op, a, b);
        exp_s = ref_stall(op, a, b);
        t = $sformatf("op%0d_%h_%h", op, a, b);
        op_i = op; rs1_i = a; rs2_i = b; en_i = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            #1;
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (op[2]) begin st_want += int'(div_stall_o); st_other += int'(mul_stall_o); end
                else       begin st_want += int'(mul_stall_o); st_other += int'(div_stall_o); end
                @(negedge clk_i);
            end
        end
        check({t, "_done_seen"}, 32'(seen), 32'd1);
        check({t, "_stall_len"}, st_want, exp_s);
        check({t, "_stall_other"}, st_other, 0);
        check({t, "_done_stall"}, 32'(op[2] ? div_stall_o : mul_stall_o), 32'd0);
        check({t, "_result"}, result_o, exp_r);
        if (freeze_n > 0) begin
            freeze_i = 1'b1;
            for (int k = 1; k < freeze_n; k++) begin
                @(negedge clk_i); #1;
                check({t, "_frz_done"}, 32'(done_o), 32'd1);
                check({t, "_frz_result"}, result_o, exp_r);
            end
            freeze_i = 1'b0;
        end
        if (op[2] && exp_s == 33) begin
            c_v = 1'b1; c_u = op[0]; c_a = a; c_b = b;
        end
        last_result = exp_r;
        if (!keep) en_i = 1'b0;
        @(negedge clk_i); #1;
        check({t, "_done_drop"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          dn;

        rst_i = 1'b1; en_i = 1'b0; freeze_i = 1'b0;
        op_i = 3'd0; rs1_i = 32'h0; rs2_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_result", result_o, 32'h0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_mul_stall", 32'(mul_stall_o), 32'd0);
        check("rst_div_stall", 32'(div_stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op(3'd0, 32'd7, 32'd6, 1'b1, 0);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
        run_op(3'd5, 32'd5, 32'd0, 1'b0, 0);
        run_op(3'd7, 32'd5, 32'd0, 1'b0, 0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);

        op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7; en_i = 1'b1;
        repeat (10) @(negedge clk_i);
        #1;
        check("sq_busy_before", 32'(busy_o), 32'd1);
        check("sq_stall_before", 32'(div_stall_o), 32'd1);
        en_i = 1'b0;
        #1;
        check("sq_stall_dropped", 32'(div_stall_o), 32'd0);
        @(negedge clk_i); #1;
        check("sq_busy_after", 32'(busy_o), 32'd0);
        check("sq_done_after", 32'(done_o), 32'd0);
        check("sq_result_kept", result_o, last_result);
        c_v = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk_i); #1;
            dn += int'(done_o);
        end
        check("sq_no_done", dn, 0);

        run_op(3'd0, 32'h1234, 32'h10, 1'b0, 4);

        op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5; en_i = 1'b1;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        check("rstmid_result", result_o, 32'h0);
        check("rstmid_done", 32'(done_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        c_v = 1'b0;
        last_result = 32'h0;
        @(negedge clk_i);
        run_op(3'd0, 32'd3, 32'd3, 1'b1, 0);
        run_op(3'd5, 32'd100, 32'd7, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(rop, ra, rb, bit'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
